// File: rtl/pic_cmd_sequencer.sv
// rtl/pic_cmd_sequencer.sv - clocked 8259 command sequencer: strobe sync, ICW FSM, OCW latches
module pic_cmd_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int INIT_TIMEOUT = 0,
  parameter int TMO_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] icw1_q,
  output logic [7:0] icw2_q,
  output logic [7:0] icw3_q,
  output logic [7:0] icw4_q,
  output logic [7:0] imr_q,
  output logic [7:0] ocw2_q,
  output logic [7:0] ocw3_q,
  output logic [2:0] wr_flag,
  output logic       wr_pulse,
  output logic [2:0] rd_sel,
  output logic       rd_pulse,
  output logic       init_done,
  output logic       poll_req,
  output logic       tmo_err
);

  typedef enum logic [2:0] {S_IDLE, S_W_ICW2, S_W_ICW3, S_W_ICW4, S_READY} state_t;

  localparam logic [2:0] RD_IRR  = 3'b001;
  localparam logic [2:0] RD_IMR  = 3'b011;
  localparam logic [2:0] RD_ISR  = 3'b101;
  localparam logic [2:0] RD_POLL = 3'b110;
  localparam bit TMO_EN = (INIT_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((INIT_TIMEOUT > 0) ? INIT_TIMEOUT - 1 : 0);

  logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d, rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0]      wr_sync_q, wr_sync_d, a0_sync_q, a0_sync_d;
  logic [SYNC_STAGES-1:0][7:0] din_sync_q, din_sync_d;
  logic       wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d, a0_prev_q, a0_prev_d;
  logic [7:0] din_prev_q, din_prev_d;
  logic       cs_s, rd_s, wr_s, a0_s;
  logic       wr_evt, rd_evt, icw_acc;

  state_t     state_q, state_d;
  logic [7:0] icw1_d, icw2_d, icw3_d, icw4_d, imr_d, ocw2_d, ocw3_d;
  logic [2:0] wr_flag_q, wr_flag_d, rd_sel_q, rd_sel_d;
  logic       wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
  logic       poll_req_q, poll_req_d, poll_pend_q, poll_pend_d;
  logic       tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    cs_sync_d     = cs_sync_q;
    rd_sync_d     = rd_sync_q;
    wr_sync_d     = wr_sync_q;
    a0_sync_d     = a0_sync_q;
    din_sync_d    = din_sync_q;
    cs_sync_d[0]  = cs_n;
    rd_sync_d[0]  = rd_n;
    wr_sync_d[0]  = wr_n;
    a0_sync_d[0]  = a0;
    din_sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      cs_sync_d[i]  = cs_sync_q[i-1];
      rd_sync_d[i]  = rd_sync_q[i-1];
      wr_sync_d[i]  = wr_sync_q[i-1];
      a0_sync_d[i]  = a0_sync_q[i-1];
      din_sync_d[i] = din_sync_q[i-1];
    end
  end

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign a0_s = a0_sync_q[SYNC_STAGES-1];

  // Write data is taken from the cycle before wr_n rose, i.e. the stable low phase.
  assign wr_prev_d  = wr_s;
  assign rd_prev_d  = rd_s;
  assign a0_prev_d  = a0_s;
  assign din_prev_d = din_sync_q[SYNC_STAGES-1];

  assign wr_evt = wr_s & ~wr_prev_q & ~cs_s & rd_s;
  assign rd_evt = ~rd_s & rd_prev_q & ~cs_s & wr_s;

  always_comb begin
    state_d     = state_q;
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    imr_d       = imr_q;
    ocw2_d      = ocw2_q;
    ocw3_d      = ocw3_q;
    wr_flag_d   = wr_flag_q;
    wr_pulse_d  = 1'b0;
    rd_sel_d    = rd_sel_q;
    rd_pulse_d  = 1'b0;
    poll_req_d  = 1'b0;
    poll_pend_d = poll_pend_q;
    tmo_err_d   = 1'b0;
    tmo_cnt_d   = '0;
    icw_acc     = 1'b0;

    if (wr_evt && !a0_prev_q && din_prev_q[4]) begin
      icw1_d      = din_prev_q;
      icw4_d      = din_prev_q[0] ? icw4_q : 8'h00;
      imr_d       = 8'h00;
      ocw2_d      = 8'h00;
      ocw3_d      = 8'h00;
      poll_pend_d = 1'b0;
      wr_flag_d   = 3'd0;
      wr_pulse_d  = 1'b1;
      icw_acc     = 1'b1;
      state_d     = S_W_ICW2;
    end else if (wr_evt) begin
      case (state_q)
        S_W_ICW2: if (a0_prev_q) begin
          icw2_d     = din_prev_q;
          wr_flag_d  = 3'd1;
          wr_pulse_d = 1'b1;
          icw_acc    = 1'b1;
          if (!icw1_q[1])     state_d = S_W_ICW3;
          else if (icw1_q[0]) state_d = S_W_ICW4;
          else                state_d = S_READY;
        end
        S_W_ICW3: if (a0_prev_q) begin
          icw3_d     = din_prev_q;
          wr_flag_d  = 3'd2;
          wr_pulse_d = 1'b1;
          icw_acc    = 1'b1;
          state_d    = icw1_q[0] ? S_W_ICW4 : S_READY;
        end
        S_W_ICW4: if (a0_prev_q) begin
          icw4_d     = din_prev_q;
          wr_flag_d  = 3'd3;
          wr_pulse_d = 1'b1;
          icw_acc    = 1'b1;
          state_d    = S_READY;
        end
        S_READY: begin
          wr_pulse_d = 1'b1;
          if (a0_prev_q) begin
            imr_d     = din_prev_q;
            wr_flag_d = 3'd4;
          end else if (!din_prev_q[3]) begin
            ocw2_d    = din_prev_q;
            wr_flag_d = 3'd5;
          end else begin
            ocw3_d      = din_prev_q;
            wr_flag_d   = 3'd6;
            poll_req_d  = din_prev_q[2];
            poll_pend_d = poll_pend_q | din_prev_q[2];
          end
        end
        default: ;
      endcase
    end

    // Idle time between ICWs is bounded; contents survive an abort.
    if (TMO_EN && !icw_acc &&
        (state_q == S_W_ICW2 || state_q == S_W_ICW3 || state_q == S_W_ICW4)) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = S_IDLE;
        tmo_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end

    if (rd_evt) begin
      rd_pulse_d = 1'b1;
      if (a0_s) begin
        rd_sel_d = RD_IMR;
      end else if (poll_pend_q) begin
        rd_sel_d    = RD_POLL;
        poll_pend_d = 1'b0;
      end else if (state_q == S_READY && ocw3_q[1:0] == 2'b11) begin
        rd_sel_d = RD_ISR;
      end else begin
        rd_sel_d = RD_IRR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      a0_sync_q   <= '0;
      din_sync_q  <= '0;
      wr_prev_q   <= 1'b1;
      rd_prev_q   <= 1'b1;
      a0_prev_q   <= 1'b0;
      din_prev_q  <= 8'h00;
      state_q     <= S_IDLE;
      icw1_q      <= 8'h00;
      icw2_q      <= 8'h00;
      icw3_q      <= 8'h00;
      icw4_q      <= 8'h00;
      imr_q       <= 8'h00;
      ocw2_q      <= 8'h00;
      ocw3_q      <= 8'h00;
      wr_flag_q   <= 3'd0;
      wr_pulse_q  <= 1'b0;
      rd_sel_q    <= RD_IRR;
      rd_pulse_q  <= 1'b0;
      poll_req_q  <= 1'b0;
      poll_pend_q <= 1'b0;
      tmo_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      rd_sync_q   <= rd_sync_d;
      wr_sync_q   <= wr_sync_d;
      a0_sync_q   <= a0_sync_d;
      din_sync_q  <= din_sync_d;
      wr_prev_q   <= wr_prev_d;
      rd_prev_q   <= rd_prev_d;
      a0_prev_q   <= a0_prev_d;
      din_prev_q  <= din_prev_d;
      state_q     <= state_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      imr_q       <= imr_d;
      ocw2_q      <= ocw2_d;
      ocw3_q      <= ocw3_d;
      wr_flag_q   <= wr_flag_d;
      wr_pulse_q  <= wr_pulse_d;
      rd_sel_q    <= rd_sel_d;
      rd_pulse_q  <= rd_pulse_d;
      poll_req_q  <= poll_req_d;
      poll_pend_q <= poll_pend_d;
      tmo_err_q   <= tmo_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign wr_flag   = wr_flag_q;
  assign wr_pulse  = wr_pulse_q;
  assign rd_sel    = rd_sel_q;
  assign rd_pulse  = rd_pulse_q;
  assign poll_req  = poll_req_q;
  assign tmo_err   = tmo_err_q;
  assign init_done = (state_q == S_READY);

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb/tb_pic_cmd_sequencer.sv - scoreboard bench for pic_cmd_sequencer
module tb_pic_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, imr_q, ocw2_q, ocw3_q;
  logic [2:0] wr_flag, rd_sel;
  logic       wr_pulse, rd_pulse, init_done, poll_req, tmo_err;

  typedef struct {
    logic [2:0] flag;
    logic [7:0] val;
  } wexp_t;

  wexp_t      wq[$];
  logic [2:0] rq[$];
  int         pq[$];
  int         tq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_wr = 0;

  pic_cmd_sequencer #(.SYNC_STAGES(2), .INIT_TIMEOUT(50), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .din(din),
    .icw1_q(icw1_q), .icw2_q(icw2_q), .icw3_q(icw3_q), .icw4_q(icw4_q),
    .imr_q(imr_q), .ocw2_q(ocw2_q), .ocw3_q(ocw3_q),
    .wr_flag(wr_flag), .wr_pulse(wr_pulse), .rd_sel(rd_sel), .rd_pulse(rd_pulse),
    .init_done(init_done), .poll_req(poll_req), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input logic [2:0] f);
    case (f)
      3'd0: reg_of = icw1_q;
      3'd1: reg_of = icw2_q;
      3'd2: reg_of = icw3_q;
      3'd3: reg_of = icw4_q;
      3'd4: reg_of = imr_q;
      3'd5: reg_of = ocw2_q;
      3'd6: reg_of = ocw3_q;
      default: reg_of = 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    wexp_t e;
    cyc++;
    if (wr_pulse) begin
      chk("wr_pulse_expected", int'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_flag", wr_flag, e.flag);
        chk("wr_reg", reg_of(e.flag), e.val);
      end
      last_wr = cyc;
    end
    if (rd_pulse) begin
      chk("rd_pulse_expected", int'(rq.size() != 0), 1);
      if (rq.size() != 0) chk("rd_sel", rd_sel, rq.pop_front());
    end
    if (poll_req) begin
      chk("poll_req_expected", int'(pq.size() != 0), 1);
      if (pq.size() != 0) void'(pq.pop_front());
    end
    if (tmo_err) begin
      chk("tmo_err_expected", int'(tq.size() != 0), 1);
      if (tq.size() != 0) chk("tmo_latency", cyc - last_wr, tq.pop_front());
      chk("tmo_init_done", init_done, 0);
    end
  end

  task automatic exp_wr(input logic [2:0] f, input logic [7:0] v);
    wexp_t e;
    e.flag = f;
    e.val  = v;
    wq.push_back(e);
  endtask

  task automatic bus_write(input logic addr, input logic [7:0] data, input bit chk_done);
    @(posedge clk); #1;
    cs_n = 1'b0; a0 = addr; din = data; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (chk_done) chk("init_done_before_latency", init_done, 0);
    @(posedge clk);
    @(negedge clk);
    if (chk_done) chk("init_done_at_latency", init_done, 1);
    @(posedge clk); #1;
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic bus_read(input logic addr);
    @(posedge clk); #1;
    cs_n = 1'b0; a0 = addr; rd_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rd_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_icws"}, {icw1_q, icw2_q, icw3_q, icw4_q}, 32'h0);
    chk({tag, "_ocws"}, {imr_q, ocw2_q, ocw3_q}, 0);
    chk({tag, "_wr_flag"}, wr_flag, 0);
    chk({tag, "_rd_sel"}, rd_sel, 3'b001);
    chk({tag, "_pulses"}, {wr_pulse, rd_pulse, poll_req, tmo_err}, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // Writes in IDLE other than ICW1 are dropped.
    bus_write(1'b1, 8'h33, 1'b0);
    chk("idle_write_ignored", icw2_q, 8'h00);

    // Single mode, no ICW4
    exp_wr(3'd0, 8'h12); bus_write(1'b0, 8'h12, 1'b0);
    exp_wr(3'd1, 8'h20); bus_write(1'b1, 8'h20, 1'b1);
    chk("single_icw4_zero", icw4_q, 8'h00);

    // Cascade with ICW4, plus a dropped a0=0/D4=0 write in W_ICW2
    exp_wr(3'd0, 8'h11); bus_write(1'b0, 8'h11, 1'b0);
    bus_write(1'b0, 8'h08, 1'b0);
    chk("wait_icw2_ignored", init_done, 0);
    exp_wr(3'd1, 8'h08); bus_write(1'b1, 8'h08, 1'b0);
    exp_wr(3'd2, 8'h04); bus_write(1'b1, 8'h04, 1'b0);
    chk("cascade_not_done_before_icw4", init_done, 0);
    exp_wr(3'd3, 8'h01); bus_write(1'b1, 8'h01, 1'b0);
    chk("cascade_done", init_done, 1);
    chk("cascade_regs", {icw1_q, icw2_q, icw3_q, icw4_q}, 32'h11080401);
    exp_wr(3'd4, 8'hFB); bus_write(1'b1, 8'hFB, 1'b0);

    // OCW2/OCW3 and reads
    exp_wr(3'd5, 8'h20); bus_write(1'b0, 8'h20, 1'b0);
    exp_wr(3'd6, 8'h0B); bus_write(1'b0, 8'h0B, 1'b0);
    rq.push_back(3'b101); bus_read(1'b0);
    exp_wr(3'd6, 8'h0A); bus_write(1'b0, 8'h0A, 1'b0);
    rq.push_back(3'b001); bus_read(1'b0);
    rq.push_back(3'b011); bus_read(1'b1);

    // Poll command
    exp_wr(3'd6, 8'h0C); pq.push_back(1); bus_write(1'b0, 8'h0C, 1'b0);
    rq.push_back(3'b110); bus_read(1'b0);
    rq.push_back(3'b001); bus_read(1'b0);

    // ICW1 from READY clears the OCWs, then abort on timeout
    exp_wr(3'd0, 8'h11); bus_write(1'b0, 8'h11, 1'b0);
    chk("restart_imr_cleared", imr_q, 8'h00);
    chk("restart_ocw2_cleared", ocw2_q, 8'h00);
    chk("restart_init_done", init_done, 0);
    tq.push_back(50);
    exp_wr(3'd1, 8'h55); bus_write(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 100 && tq.size() != 0; i++) @(negedge clk);
    chk("tmo_seen", tq.size(), 0);
    bus_write(1'b1, 8'h99, 1'b0);
    chk("tmo_keeps_icw2", icw2_q, 8'h55);
    chk("tmo_idle_ignores_a0_write", icw3_q, 8'h04);
    chk("tmo_init_done_after", init_done, 0);

    // Reset mid-sequence
    rq.push_back(3'b011); bus_read(1'b1);
    exp_wr(3'd0, 8'h11); bus_write(1'b0, 8'h11, 1'b0);
    exp_wr(3'd1, 8'h08); bus_write(1'b1, 8'h08, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midseq_reset");
    bus_write(1'b1, 8'h77, 1'b0);
    chk("post_reset_write_ignored", {icw2_q, icw3_q}, 0);

    for (int i = 0; i < 50 && (wq.size() + rq.size() + pq.size()) != 0; i++) @(negedge clk);
    chk("wr_queue_drained", wq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    chk("poll_queue_drained", pq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
